// File: rtl/sweep_pkg.sv
// Shared definitions for the exhaustive-sweep checker: FSM state codes and vector ordering.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package sweep_pkg;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Binary-reflected Gray code of a sweep index (wide enough for N_IN up to 8)
  function automatic logic [7:0] gray_of(input logic [7:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/sweep_index_gen.sv
// Walks the sweep index, holds each vector for DWELL clocks, flags the sample edge and the last vector.
// Latency: vec updates on the same edge as the sample of the previous vector (no gap cycles).
// Backpressure: none; advances every clock while run_i is high, clear_i restarts from vector 0.
module sweep_index_gen
  import sweep_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int DWELL = 20,
  parameter int GRAY  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            run_i,
  output logic [N_IN-1:0] vec_o,
  output logic            sample_en_o,
  output logic            last_o
);

  localparam int               DW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]    DWELL_MAX = DW'(DWELL - 1);
  localparam logic [N_IN:0]    IDX_LAST  = (N_IN + 1)'((1 << N_IN) - 1);

  logic [N_IN:0]   idx_q, idx_d, idx_inc;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [N_IN-1:0] vec_q, vec_d, vec_nxt;

  assign sample_en_o = run_i && (dwell_q == DWELL_MAX);
  assign last_o      = (idx_q == IDX_LAST);
  assign vec_o       = vec_q;

  // Next-state for the index/dwell counters and the applied vector
  always_comb begin
    idx_d   = idx_q;
    dwell_d = dwell_q;
    vec_d   = vec_q;
    idx_inc = idx_q + 1'b1;
    if (GRAY != 0) vec_nxt = N_IN'(gray_of(8'(idx_inc[N_IN-1:0])));
    else           vec_nxt = idx_inc[N_IN-1:0];

    if (clear_i) begin
      idx_d   = '0;
      dwell_d = '0;
      vec_d   = '0;
    end else if (run_i) begin
      if (dwell_q == DWELL_MAX) begin
        dwell_d = '0;
        idx_d   = idx_inc;
        // The last vector stays on the bus after the sweep ends.
        if (!last_o) vec_d = vec_nxt;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  // Counter and vector registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      dwell_q <= '0;
      vec_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      vec_q   <= vec_d;
    end
  end

endmodule

// File: rtl/sweep_checker.sv
// Exhaustive-stimulus checker: sweeps all N_IN-bit vectors and compares dut_f against EXP_TABLE.
// Latency: done rises 2**N_IN*DWELL clocks after the accepted start edge.
// Backpressure: none; start is ignored while a sweep is running.
module sweep_checker
  import sweep_pkg::*;
#(
  parameter int                   N_IN      = 4,
  parameter int                   DWELL     = 20,
  parameter int                   GRAY      = 0,
  parameter logic [(1<<N_IN)-1:0] EXP_TABLE = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_f,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_vld
);

  logic [1:0]      state_q, state_d;
  logic [N_IN:0]   err_q, err_d, err_inc;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            ffv_q, ffv_d;
  logic            pass_q, pass_d;
  logic            running, start_acc, sample_en, last, mismatch;

  assign running   = (state_q == ST_RUN);
  assign start_acc = start && !running;

  sweep_index_gen #(
    .N_IN  (N_IN),
    .DWELL (DWELL),
    .GRAY  (GRAY)
  ) u_index_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (start_acc),
    .run_i       (running),
    .vec_o       (vec),
    .sample_en_o (sample_en),
    .last_o      (last)
  );

  // Compare the sample against the table and update the result registers
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    ff_d     = ff_q;
    ffv_d    = ffv_q;
    pass_d   = pass_q;
    mismatch = (dut_f != EXP_TABLE[vec]);
    err_inc  = err_q + (N_IN + 1)'(mismatch);

    if (start_acc) begin
      state_d = ST_RUN;
      err_d   = '0;
      ff_d    = '0;
      ffv_d   = 1'b0;
      pass_d  = 1'b0;
    end else if (running && sample_en) begin
      err_d = err_inc;
      if (mismatch && !ffv_q) begin
        ff_d  = vec;
        ffv_d = 1'b1;
      end
      if (last) begin
        state_d = ST_DONE;
        pass_d  = (err_inc == '0);
      end
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  assign busy           = running;
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_sweep_checker.sv
// Bench: three checker instances (binary/DWELL=20, binary/DWELL=1, Gray/DWELL=3) against fault-injected table models.
// Latency: expected done latency and results come from a per-sweep reference model.
// Backpressure: not applicable.
module tb_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_s   [3];
  logic        dut_f_s   [3];
  logic [3:0]  vec_s     [3];
  logic        busy_s    [3];
  logic        done_s    [3];
  logic        pass_s    [3];
  logic [4:0]  err_s     [3];
  logic [3:0]  ff_s      [3];
  logic        ffv_s     [3];
  logic [15:0] tbl       [3];
  logic [15:0] fmask     [3];

  int dwl [3] = '{20, 1, 3};
  int gry [3] = '{0, 0, 1};

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural DUT: the expected table with selected vectors inverted
  for (genvar g = 0; g < 3; g++) begin : g_model
    assign dut_f_s[g] = tbl[g][vec_s[g]] ^ fmask[g][vec_s[g]];
  end

  sweep_checker #(.N_IN(4), .DWELL(20), .GRAY(0), .EXP_TABLE(16'hA5C3)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .dut_f(dut_f_s[0]), .vec(vec_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_cnt(err_s[0]),
    .first_fail(ff_s[0]), .first_fail_vld(ffv_s[0]));

  sweep_checker #(.N_IN(4), .DWELL(1), .GRAY(0), .EXP_TABLE(16'hA5C3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .dut_f(dut_f_s[1]), .vec(vec_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_cnt(err_s[1]),
    .first_fail(ff_s[1]), .first_fail_vld(ffv_s[1]));

  sweep_checker #(.N_IN(4), .DWELL(3), .GRAY(1), .EXP_TABLE(16'h3C96)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .dut_f(dut_f_s[2]), .vec(vec_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_cnt(err_s[2]),
    .first_fail(ff_s[2]), .first_fail_vld(ffv_s[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // One full sweep on instance k with fault mask 'mask'; optionally pulse start at cycle 50
  task automatic run_sweep(input int k, input logic [15:0] mask, input bit poke);
    int d, exp_err, exp_ff, lat, bad;
    bit exp_ffv;
    int order [16];
    d = dwl[k];
    exp_err = 0; exp_ff = 0; exp_ffv = 0;
    for (int i = 0; i < 16; i++) begin
      order[i] = (gry[k] != 0) ? (i ^ (i >> 1)) : i;
      if (mask[order[i]]) begin
        exp_err++;
        if (!exp_ffv) begin
          exp_ffv = 1;
          exp_ff  = order[i];
        end
      end
    end
    fmask[k] = mask;
    @(posedge clk); #1 start_s[k] = 1'b1;
    @(posedge clk); #1 start_s[k] = 1'b0;
    chk($sformatf("i%0d_busy_at_start", k), 32'(busy_s[k]), 32'd1);
    chk($sformatf("i%0d_cleared", k), {done_s[k], pass_s[k], ffv_s[k], 24'd0, 5'(err_s[k])}, 32'd0);
    lat = -1;
    bad = 0;
    for (int c = 0; c < 16 * d + 8 && lat < 0; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start_s[k] = 1'b0;
      end
      if (done_s[k]) lat = c;
      else if (c / d < 16 && vec_s[k] != 4'(order[c / d])) bad++;
      if (poke && c == 50) start_s[k] = 1'b1;
    end
    chk($sformatf("i%0d_latency", k), 32'(lat), 32'(16 * d));
    chk($sformatf("i%0d_vec_seq_bad", k), 32'(bad), 32'd0);
    chk($sformatf("i%0d_vec_hold", k), 32'(vec_s[k]), 32'(order[15]));
    chk($sformatf("i%0d_busy_end", k), 32'(busy_s[k]), 32'd0);
    chk($sformatf("i%0d_pass", k), 32'(pass_s[k]), 32'(exp_err == 0));
    chk($sformatf("i%0d_err_cnt", k), 32'(err_s[k]), 32'(exp_err));
    chk($sformatf("i%0d_first_fail_vld", k), 32'(ffv_s[k]), 32'(exp_ffv));
    chk($sformatf("i%0d_first_fail", k), 32'(ff_s[k]), 32'(exp_ff));
    repeat (3) @(posedge clk);
    #1 chk($sformatf("i%0d_done_persist", k), {done_s[k], 26'd0, 5'(err_s[k])}, {1'b1, 26'd0, 5'(exp_err)});
  endtask

  initial begin
    rst_n = 1'b0;
    tbl[0] = 16'hA5C3; tbl[1] = 16'hA5C3; tbl[2] = 16'h3C96;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      fmask[k]   = 16'h0000;
    end
    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("i%0d_rst_flags", k),
          {busy_s[k], done_s[k], pass_s[k], ffv_s[k], 28'd0}, 32'd0);
      chk($sformatf("i%0d_rst_data", k), {19'd0, vec_s[k], err_s[k], ff_s[k]}, 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;

    // Directed cases
    run_sweep(0, 16'h0000, 1'b0);                // correct DUT
    run_sweep(0, 16'h0200, 1'b0);                // single fault at vector 9
    run_sweep(1, 16'hFFFF, 1'b0);                // all wrong, DWELL=1
    run_sweep(2, 16'h0000, 1'b0);                // Gray order, correct DUT
    run_sweep(0, 16'($urandom) & 16'($urandom), 1'b1);  // restart from DONE, mid-sweep start ignored

    // Asynchronous reset in the middle of a sweep
    fmask[0] = 16'h0003;
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    repeat (100) @(posedge clk);
    #1 chk("pre_rst_err_cnt", 32'(err_s[0]), 32'd2);
    rst_n = 1'b0;
    #1 chk("mid_rst_flags", {busy_s[0], done_s[0], pass_s[0], ffv_s[0], 28'd0}, 32'd0);
    chk("mid_rst_data", {19'd0, vec_s[0], err_s[0], ff_s[0]}, 32'd0);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("no_resume_busy", 32'(busy_s[0]), 32'd0);
    run_sweep(0, 16'($urandom), 1'b0);

    // Randomized fault masks on all instances
    for (int r = 0; r < 6; r++) begin
      run_sweep(1 + (r % 2), 16'($urandom) & 16'($urandom_range(0, 65535)), 1'b0);
    end
    run_sweep(2, 16'hFFFF, 1'b0);
    run_sweep(0, 16'($urandom), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
